// File: rtl/ps2_pkg.sv
// Shared constants, FSM encoding and event layout for the PS/2 scan-code decoder.
package ps2_pkg;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_E1     = 8'hE1;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_RESEND = 8'hFE;

    // Bytes following E1 (Pause/Break) that are swallowed
    localparam logic [2:0] E1_DROP_LEN = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        GOT_E0,
        GOT_F0,
        GOT_E0F0,
        DROP
    } ps2_state_e;

    typedef struct packed {
        logic       ext;
        logic       make;
        logic [7:0] code;
        logic [7:0] ascii;
    } key_evt_t;

    function automatic logic is_ctrl_byte(input logic [7:0] b);
        return (b == SC_BAT) || (b == SC_ACK) || (b == SC_ECHO) || (b == SC_RESEND);
    endfunction

endpackage

// File: rtl/ps2_ascii_map.sv
// Combinational scan-code set 2 to ASCII lookup with shift/caps handling.
module ps2_ascii_map (
    input  logic [7:0] code_i,
    input  logic       ext_i,
    input  logic       shift_i,
    input  logic       caps_i,
    output logic [7:0] ascii_o
);

    logic [7:0] lower, num, num_sh, ctl;

    always_comb begin
        lower  = '0;
        num    = '0;
        num_sh = '0;
        ctl    = '0;
        case (code_i)
            8'h1C: lower = 8'h61;  8'h32: lower = 8'h62;  8'h21: lower = 8'h63;
            8'h23: lower = 8'h64;  8'h24: lower = 8'h65;  8'h2B: lower = 8'h66;
            8'h34: lower = 8'h67;  8'h33: lower = 8'h68;  8'h43: lower = 8'h69;
            8'h3B: lower = 8'h6A;  8'h42: lower = 8'h6B;  8'h4B: lower = 8'h6C;
            8'h3A: lower = 8'h6D;  8'h31: lower = 8'h6E;  8'h44: lower = 8'h6F;
            8'h4D: lower = 8'h70;  8'h15: lower = 8'h71;  8'h2D: lower = 8'h72;
            8'h1B: lower = 8'h73;  8'h2C: lower = 8'h74;  8'h3C: lower = 8'h75;
            8'h2A: lower = 8'h76;  8'h1D: lower = 8'h77;  8'h22: lower = 8'h78;
            8'h35: lower = 8'h79;  8'h1A: lower = 8'h7A;
            8'h45: begin num = 8'h30; num_sh = 8'h29; end
            8'h16: begin num = 8'h31; num_sh = 8'h21; end
            8'h1E: begin num = 8'h32; num_sh = 8'h40; end
            8'h26: begin num = 8'h33; num_sh = 8'h23; end
            8'h25: begin num = 8'h34; num_sh = 8'h24; end
            8'h2E: begin num = 8'h35; num_sh = 8'h25; end
            8'h36: begin num = 8'h36; num_sh = 8'h5E; end
            8'h3D: begin num = 8'h37; num_sh = 8'h26; end
            8'h3E: begin num = 8'h38; num_sh = 8'h2A; end
            8'h46: begin num = 8'h39; num_sh = 8'h28; end
            8'h29: ctl = 8'h20;
            8'h5A: ctl = 8'h0D;
            8'h66: ctl = 8'h08;
            8'h0D: ctl = 8'h09;
            8'h76: ctl = 8'h1B;
            default: ;
        endcase

        // Only keypad Enter is meaningful among E0-prefixed codes
        if (ext_i)
            ascii_o = (code_i == 8'h5A) ? 8'h0D : 8'h00;
        else if (lower != 8'h00)
            ascii_o = (shift_i ^ caps_i) ? lower - 8'h20 : lower;
        else if (num != 8'h00)
            ascii_o = shift_i ? num_sh : num;
        else
            ascii_o = ctl;
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 byte stream to key events: prefix FSM, modifier tracking, event FIFO.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] scan_code,
    input  logic       new_data,
    input  logic       key_ready,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic [7:0] key_ascii,
    output logic       key_make,
    output logic       key_extended,
    output logic       shift_active,
    output logic       caps_lock,
    output logic       overflow
);

    localparam int         AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    logic       nd_q, accept;
    ps2_state_e state_q, state_d;
    logic [2:0] drop_q, drop_d;
    logic       evt_vld, evt_make, evt_ext;
    logic [7:0] evt_ascii;
    logic       lshift_q, lshift_d, rshift_q, rshift_d;
    logic       caps_held_q, caps_held_d, caps_q, caps_d;

    key_evt_t      mem_q [FIFO_DEPTH];
    key_evt_t      evt, head;
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          full, pop, push_ok, overflow_q;

    assign accept = new_data & ~nd_q;

    always_comb begin
        state_d  = state_q;
        drop_d   = drop_q;
        evt_vld  = 1'b0;
        evt_make = 1'b0;
        evt_ext  = 1'b0;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (scan_code == SC_E0)
                        state_d = GOT_E0;
                    else if (scan_code == SC_F0)
                        state_d = GOT_F0;
                    else if (scan_code == SC_E1) begin
                        state_d = DROP;
                        drop_d  = E1_DROP_LEN;
                    end else if (!is_ctrl_byte(scan_code)) begin
                        evt_vld  = 1'b1;
                        evt_make = 1'b1;
                    end
                end
                GOT_E0: begin
                    if (scan_code == SC_F0)
                        state_d = GOT_E0F0;
                    else begin
                        state_d  = IDLE;
                        evt_vld  = (scan_code != SC_LSHIFT);
                        evt_make = 1'b1;
                        evt_ext  = 1'b1;
                    end
                end
                GOT_F0: begin
                    state_d = IDLE;
                    evt_vld = 1'b1;
                end
                GOT_E0F0: begin
                    state_d = IDLE;
                    evt_vld = (scan_code != SC_LSHIFT);
                    evt_ext = 1'b1;
                end
                DROP: begin
                    drop_d = drop_q - 3'd1;
                    if (drop_q == 3'd1)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Modifiers update even when the FIFO drops the event
    always_comb begin
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        caps_held_d = caps_held_q;
        caps_d      = caps_q;
        if (evt_vld && !evt_ext) begin
            case (scan_code)
                SC_LSHIFT: lshift_d = evt_make;
                SC_RSHIFT: rshift_d = evt_make;
                SC_CAPS: begin
                    caps_held_d = evt_make;
                    if (evt_make && !caps_held_q)
                        caps_d = ~caps_q;
                end
                default: ;
            endcase
        end
    end

    ps2_ascii_map u_ascii (
        .code_i  (scan_code),
        .ext_i   (evt_ext),
        .shift_i (lshift_q | rshift_q),
        .caps_i  (caps_q),
        .ascii_o (evt_ascii)
    );

    assign evt     = '{ext: evt_ext, make: evt_make, code: scan_code, ascii: evt_ascii};
    assign full    = (cnt_q == FULL_CNT);
    assign pop     = key_valid & key_ready;
    assign push_ok = evt_vld & (~full | pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nd_q        <= 1'b1;
            state_q     <= IDLE;
            drop_q      <= '0;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            caps_held_q <= 1'b0;
            caps_q      <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            nd_q        <= new_data;
            state_q     <= state_d;
            drop_q      <= drop_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            caps_held_q <= caps_held_d;
            caps_q      <= caps_d;
            if (push_ok) begin
                mem_q[wr_q] <= evt;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop)
                rd_q <= rd_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: ;
            endcase
            overflow_q <= evt_vld & full & ~pop;
        end
    end

    assign head         = mem_q[rd_q];
    assign key_valid    = (cnt_q != '0);
    assign key_code     = key_valid ? head.code  : 8'h00;
    assign key_ascii    = key_valid ? head.ascii : 8'h00;
    assign key_make     = key_valid & head.make;
    assign key_extended = key_valid & head.ext;
    assign shift_active = lshift_q | rshift_q;
    assign caps_lock    = caps_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: directed scenarios plus a random byte stream vs a reference model.
module tb_ps2_scancode_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] scan_code;
    logic       new_data;
    logic       key_ready;
    logic       key_valid;
    logic [7:0] key_code;
    logic [7:0] key_ascii;
    logic       key_make;
    logic       key_extended;
    logic       shift_active;
    logic       caps_lock;
    logic       overflow;

    always #5 clk = ~clk;

    ps2_scancode_decoder #(.FIFO_DEPTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scan_code    (scan_code),
        .new_data     (new_data),
        .key_ready    (key_ready),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_ascii    (key_ascii),
        .key_make     (key_make),
        .key_extended (key_extended),
        .shift_active (shift_active),
        .caps_lock    (caps_lock),
        .overflow     (overflow)
    );

    typedef struct packed {
        logic [7:0] code;
        logic [7:0] ascii;
        logic       make;
        logic       ext;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  ovf_seen = 0;
    bit  rnd_ready = 1'b0;

    // Reference model state: which prefixes have been seen, bytes left to skip
    bit m_e0, m_f0, m_lsh, m_rsh, m_caps, m_caps_held;
    int m_skip;

    string      LOWER = "abcdefghijklmnopqrstuvwxyz";
    string      UPPER = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
    string      DIGS  = "0123456789";
    string      DSYM  = ")!@#$%^&*(";
    logic [7:0] LET_CODES [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                   8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                   8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] DIG_CODES [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] POOL [22] = '{8'h1C, 8'h32, 8'h45, 8'h16, 8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76, 8'h12, 8'h59,
                              8'h58, 8'h75, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'hE1, 8'h14, 8'h1A};

    function automatic logic [7:0] ref_ascii(logic [7:0] c, bit ext, bit sh, bit cp);
        if (ext) return (c == 8'h5A) ? 8'h0D : 8'h00;
        for (int i = 0; i < 26; i++)
            if (c == LET_CODES[i]) return (sh ^ cp) ? UPPER[i] : LOWER[i];
        for (int i = 0; i < 10; i++)
            if (c == DIG_CODES[i]) return sh ? DSYM[i] : DIGS[i];
        case (c)
            8'h29:   return 8'h20;
            8'h5A:   return 8'h0D;
            8'h66:   return 8'h08;
            8'h0D:   return 8'h09;
            8'h76:   return 8'h1B;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_e0 = 0; m_f0 = 0; m_lsh = 0; m_rsh = 0; m_caps = 0; m_caps_held = 0; m_skip = 0;
    endtask

    task automatic model_emit(logic [7:0] c, bit make, bit ext);
        ev_t e;
        e.code  = c;
        e.make  = make;
        e.ext   = ext;
        e.ascii = ref_ascii(c, ext, m_lsh | m_rsh, m_caps);
        exp_q.push_back(e);
        if (!ext) begin
            if (c == 8'h12) m_lsh = make;
            if (c == 8'h59) m_rsh = make;
            if (c == 8'h58) begin
                if (make && !m_caps_held) m_caps = !m_caps;
                m_caps_held = make;
            end
        end
    endtask

    task automatic model_byte(logic [7:0] b);
        if (m_skip > 0) begin
            m_skip--;
        end else if (!m_e0 && !m_f0) begin
            if (b == 8'hE0) m_e0 = 1;
            else if (b == 8'hF0) m_f0 = 1;
            else if (b == 8'hE1) m_skip = 7;
            else if (!(b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE})) model_emit(b, 1, 0);
        end else if (m_e0 && !m_f0) begin
            if (b == 8'hF0) m_f0 = 1;
            else begin
                m_e0 = 0;
                if (b != 8'h12) model_emit(b, 1, 1);
            end
        end else if (!m_e0) begin
            m_f0 = 0;
            model_emit(b, 0, 0);
        end else begin
            m_e0 = 0; m_f0 = 0;
            if (b != 8'h12) model_emit(b, 0, 1);
        end
    endtask

    // One cycle: record any pop about to happen and any overflow pulse, then advance
    task automatic step();
        if (rnd_ready)
            key_ready = (exp_q.size() - obs_q.size() >= 5) ? 1'b1 : ($urandom_range(0, 3) != 0);
        if (key_valid && key_ready)
            obs_q.push_back({key_code, key_ascii, key_make, key_extended});
        if (overflow) ovf_seen++;
        @(negedge clk);
    endtask

    task automatic send_byte(logic [7:0] b, int hold = 1, int gap = 1);
        scan_code = b;
        new_data  = 1'b1;
        model_byte(b);
        repeat (hold) step();
        new_data = 1'b0;
        repeat (gap) step();
    endtask

    task automatic drain();
        key_ready = 1'b1;
        repeat (12) step();
    endtask

    task automatic clear_q();
        exp_q.delete();
        obs_q.delete();
        ovf_seen = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; new_data = 1'b1; scan_code = 8'h1C; key_ready = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        model_reset();
        step();
        n_checks++;
        if ({key_valid, key_code, key_ascii, key_make, key_extended, shift_active, caps_lock, overflow} !== 22'h0)
            $display("FAIL reset_state got %b want all zero",
                     {key_valid, key_code, key_ascii, key_make, key_extended, shift_active, caps_lock, overflow});
        else n_pass++;
        repeat (3) step();
        n_checks++;
        if (key_valid !== 1'b0) $display("FAIL held_strobe_ignored got key_valid=%b want 0", key_valid);
        else n_pass++;
        new_data = 1'b0;
        step();
        clear_q();
    endtask

    task automatic test_basic();
        clear_q();
        key_ready = 1'b1;
        send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C, 3, 2);
        drain();
        n_checks++;
        if (obs_q.size() !== 2) $display("FAIL basic_count got %0d want 2", obs_q.size());
        else n_pass++;
        n_checks++;
        if (obs_q[0] !== {8'h1C, 8'h61, 1'b1, 1'b0}) $display("FAIL basic_make got %h want %h", obs_q[0], {8'h1C, 8'h61, 1'b1, 1'b0});
        else n_pass++;
        n_checks++;
        if (obs_q[1] !== {8'h1C, 8'h61, 1'b0, 1'b0}) $display("FAIL basic_break got %h want %h", obs_q[1], {8'h1C, 8'h61, 1'b0, 1'b0});
        else n_pass++;
    endtask

    task automatic test_shift();
        clear_q();
        key_ready = 1'b1;
        send_byte(8'h12);
        n_checks++;
        if (shift_active !== 1'b1) $display("FAIL shift_held got %b want 1", shift_active);
        else n_pass++;
        send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h12);
        n_checks++;
        if (shift_active !== 1'b0) $display("FAIL shift_released got %b want 0", shift_active);
        else n_pass++;
        send_byte(8'h1C);
        drain();
        n_checks++;
        if (obs_q[1] !== {8'h1C, 8'h41, 1'b1, 1'b0}) $display("FAIL shift_upper got %h want %h", obs_q[1], {8'h1C, 8'h41, 1'b1, 1'b0});
        else n_pass++;
        n_checks++;
        if (obs_q[3] !== {8'h1C, 8'h61, 1'b1, 1'b0}) $display("FAIL shift_lower got %h want %h", obs_q[3], {8'h1C, 8'h61, 1'b1, 1'b0});
        else n_pass++;
        n_checks++;
        if (obs_q.size() !== 4) $display("FAIL shift_count got %0d want 4", obs_q.size());
        else n_pass++;
    endtask

    task automatic test_extended();
        clear_q();
        key_ready = 1'b1;
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'h12);
        send_byte(8'hE0); send_byte(8'h5A);
        drain();
        n_checks++;
        if (obs_q.size() !== 3) $display("FAIL ext_count got %0d want 3", obs_q.size());
        else n_pass++;
        n_checks++;
        if (obs_q[0] !== {8'h75, 8'h00, 1'b1, 1'b1}) $display("FAIL ext_make got %h want %h", obs_q[0], {8'h75, 8'h00, 1'b1, 1'b1});
        else n_pass++;
        n_checks++;
        if (obs_q[1] !== {8'h75, 8'h00, 1'b0, 1'b1}) $display("FAIL ext_break got %h want %h", obs_q[1], {8'h75, 8'h00, 1'b0, 1'b1});
        else n_pass++;
        n_checks++;
        if (obs_q[2] !== {8'h5A, 8'h0D, 1'b1, 1'b1}) $display("FAIL ext_enter got %h want %h", obs_q[2], {8'h5A, 8'h0D, 1'b1, 1'b1});
        else n_pass++;
    endtask

    task automatic test_caps();
        logic [7:0] seq  [6] = '{8'h58, 8'h58, 8'h58, 8'hF0, 8'h58, 8'h58};
        bit         want [6] = '{1, 1, 1, 1, 1, 0};
        clear_q();
        key_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_byte(seq[i], 2, 1);
            if (i == 3) continue;
            n_checks++;
            if (caps_lock !== want[i]) $display("FAIL caps_step%0d got %b want %b", i, caps_lock, want[i]);
            else n_pass++;
        end
        send_byte(8'hF0); send_byte(8'h58);
        drain();
    endtask

    task automatic test_overflow();
        clear_q();
        key_ready = 1'b0;
        for (int i = 0; i < 9; i++) send_byte(LET_CODES[i], 1, 2);
        n_checks++;
        if (ovf_seen !== 1) $display("FAIL ovf_pulses got %0d want 1", ovf_seen);
        else n_pass++;
        void'(exp_q.pop_back());
        drain();
        n_checks++;
        if (obs_q.size() !== 8) $display("FAIL ovf_queued got %0d want 8", obs_q.size());
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL ovf_ev%0d got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        clear_q();
        foreach (POOL[i]) if (0) ;
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        drain();
        n_checks++;
        if (obs_q.size() !== 0) $display("FAIL pause_dropped got %0d events want 0", obs_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        clear_q();
        key_ready = 1'b0;
        send_byte(8'h1C); send_byte(8'hF0);
        rst_n = 1'b0;
        step();
        n_checks++;
        if (key_valid !== 1'b0) $display("FAIL midreset_valid got %b want 0", key_valid);
        else n_pass++;
        rst_n = 1'b1;
        model_reset();
        step();
        clear_q();
        key_ready = 1'b1;
        send_byte(8'h1C);
        drain();
        n_checks++;
        if (obs_q.size() !== 1 || obs_q[0] !== {8'h1C, 8'h61, 1'b1, 1'b0})
            $display("FAIL midreset_make got n=%0d ev=%h want n=1 ev=%h", obs_q.size(), obs_q[0], {8'h1C, 8'h61, 1'b1, 1'b0});
        else n_pass++;
    endtask

    task automatic test_random();
        clear_q();
        rnd_ready = 1'b1;
        for (int i = 0; i < 250; i++)
            send_byte(POOL[$urandom_range(0, 21)], $urandom_range(1, 3), $urandom_range(1, 2));
        rnd_ready = 1'b0;
        drain();
        n_checks++;
        if (ovf_seen !== 0) $display("FAIL rand_overflow got %0d want 0", ovf_seen);
        else n_pass++;
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL rand_ev%0d got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if ({shift_active, caps_lock} !== {m_lsh | m_rsh, m_caps})
            $display("FAIL rand_mods got %b want %b", {shift_active, caps_lock}, {m_lsh | m_rsh, m_caps});
        else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; new_data = 1'b0; scan_code = 8'h00; key_ready = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_basic();
        test_shift();
        test_extended();
        test_caps();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning event FIFO entries (power of two, 2..32).
REQ-002 SHALL have port clk  input  1  system clock, the only clock; all logic on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port scan_code  input  8  byte from the upstream PS/2 receiver.
REQ-005 SHALL have port new_data  input  1  receiver byte strobe, may stay high multiple cycles.
REQ-006 SHALL have port key_ready  input  1  consumer accepts the head event.
REQ-007 SHALL have port key_valid  output  1  FIFO non-empty, head event presented.
REQ-008 SHALL have port key_code  output  8  raw final scan code of the head event.
REQ-009 SHALL have port key_ascii  output  8  ASCII of the head event, 0x00 if unmapped.
REQ-010 SHALL have port key_make  output  1  1 = press, 0 = release.
REQ-011 SHALL have port key_extended  output  1  event was E0-prefixed.
REQ-012 SHALL have port shift_active  output  1  either shift key currently held.
REQ-013 SHALL have port caps_lock  output  1  caps lock toggle state.
REQ-014 SHALL have port overflow  output  1  one-cycle pulse when an event is dropped.

Function
REQ-015 SHALL accept a byte only on the cycle new_data is high while its registered previous value is low; all other cycles are ignored.
REQ-016 SHALL implement FSM states IDLE, GOT_E0, GOT_F0, GOT_E0F0, DROP.
REQ-017 SHALL transition IDLE: E0->GOT_E0; F0->GOT_F0; E1->DROP with drop count 7; AA/FA/EE/FE discarded, stay IDLE; other byte->emit make (ext=0), stay IDLE.
REQ-018 SHALL transition GOT_E0: F0->GOT_E0F0; 12 (fake shift)->IDLE, no event; other->emit make (ext=1), IDLE.
REQ-019 SHALL transition GOT_F0: any byte->emit break (ext=0), IDLE; GOT_E0F0: 12->IDLE no event, other->emit break (ext=1), IDLE.
REQ-020 SHALL, in DROP, discard accepted bytes, decrementing the count, and return to IDLE after the 7th.
REQ-021 SHALL track left shift (12) and right shift (59), non-extended, as separate held flags; shift_active = OR of both.
REQ-022 SHALL toggle caps_lock on a non-extended make of 58 only if caps was not already held; the held flag clears on its break (typematic repeats do not toggle).
REQ-023 SHALL map ASCII: letters a-z (uppercase when shift XOR caps), digits 0-9 (shifted symbols when shift only), 29->0x20, 5A->0x0D (also E0 5A), 66->0x08, 0D->0x09, 76->0x1B; other extended->0x00; ASCII computed with modifier state before the current event updates it.
REQ-024 SHALL push every emitted event (make and break, modifiers included) into the FIFO at the end of the accepting cycle; key_valid high the following cycle (1-cycle latency).
REQ-025 SHALL pop on key_valid && key_ready; outputs stable while key_valid && !key_ready.
REQ-026 SHALL, when full and not popping, drop the new event and pulse overflow for one cycle; simultaneous push and pop when full SHALL both succeed.
REQ-027 SHALL, with push and pop on empty, present the event next cycle (no bypass).

Reset
REQ-028 SHALL, while rst_n low at posedge clk: FSM->IDLE, drop count 0, FIFO empty, key_valid 0, key_code/key_ascii 0x00, key_make 0, key_extended 0, shift flags, caps held and caps_lock 0, overflow 0, previous new_data register 1 (a strobe held through reset is not accepted).
REQ-029 SHALL discard any partial prefix sequence on reset mid-operation.

Structure
REQ-030 SHALL place scan-code constants (E0, F0, E1, shift/caps codes), the FSM state encoding and the FIFO entry layout {ext, make, code, ascii} in shared package ps2_pkg.
REQ-031 SHALL implement the ASCII lookup as combinational sub-module ps2_ascii_map (code, ext, shift, caps -> ascii).

Verification
REQ-032 SHALL cover: strobe 1C then F0,1C, key_ready=1 -> events {1C,'a',make=1,ext=0} then {1C,'a',make=0}.
REQ-033 SHALL cover: 12, 1C, F0 12, 1C -> ASCII 'A' (0x41) then 'a' (0x61); shift_active 1 then 0.
REQ-034 SHALL cover: E0 75, E0 F0 75 -> code 75 ext=1 ascii 0x00 make then break; E0 12 -> no event.
REQ-035 SHALL cover: 58,58,58,F0 58,58 -> caps_lock 1 after first, stays 1 through repeats, 0 after last.
REQ-036 SHALL cover: key_ready=0, 9 makes with FIFO_DEPTH=8 -> 8 queued, one overflow pulse; E1 14 77 E1 F0 14 F0 77 -> no events.
REQ-037 SHALL cover: rst_n low for one cycle after F0 with FIFO non-empty -> key_valid 0 next cycle; following 1C yields make, not break.
